ip_bus_hub: RTL
===============

# ip_bus_hub

Parametrised slave-side interconnect between the cZ80 bus master and N bus peripherals (ROM, RAM, UART, test controller, future devices). It replaces the flat OR-combining of ready/rdata/rdata_en at the top level with:
- registered address decoding per channel;
- read-response tracking per request;
- a timeout watchdog, so a missing or dead slave can never hang the CPU.

## Interface
Parameters:
- CH = 4 : number of slave channels (1..16)
- AW = 16 : bus address width
- DW = 8 : data width
- CH_BASE = {CH{16'h0000}} : flattened CH×AW base addresses; channel i in bits [i*AW +: AW]
- CH_MASK = {CH{16'h0000}} : flattened CH×AW compare masks; 1 = compared bit
- CH_IO = {CH{1'b0}} : per channel; 1 = decodes bus_ioreq, 0 = decodes bus_memreq
- TIMEOUT = 255 : cycles to wait for read data before a forced response (1..65535)
- FILL = 8'hFF : data returned for unmapped or timed-out reads

Ports:
- clk  in  1  system clock (clk44m domain)
- reset  in  1  asynchronous, active-high reset
- bus_address  in  AW  master address
- bus_memreq  in  1  memory request qualifier
- bus_ioreq  in  1  I/O request qualifier
- bus_write  in  1  1 = write, 0 = read
- bus_valid  in  1  request valid; held until accepted
- bus_ready  out  1  request accepted when bus_valid & bus_ready
- bus_wdata  in  DW  write data
- bus_rdata  out  DW  read data; 0 when bus_rdata_en = 0
- bus_rdata_en  out  1  one-cycle read-data strobe
- ch_valid  out  CH  per-channel request valid
- ch_ready  in  CH  per-channel ready
- ch_rdata  in  CH×DW  per-channel read data, flattened
- ch_rdata_en  in  CH  per-channel read strobe
- err_unmapped  out  1  one-cycle pulse: a request hit no channel
- err_timeout  out  1  one-cycle pulse: a read timed out

bus_address and bus_wdata fan out to the slaves at top level; they are not routed through this block.

## Operation
- Decode: channel i hits when:
  - (bus_address & CH_MASK[i]) == (CH_BASE[i] & CH_MASK[i]); and
  - the qualifier matches CH_IO[i].
- On overlapping hits, the lowest index wins. Decode is combinational from the master inputs.
- Valid forwarding:
  - ch_valid[sel] = bus_valid, only in state IDLE; all other ch_valid are 0.
  - bus_ready = ch_ready[sel] in IDLE; otherwise 0.
- Unmapped request (no hit, memreq or ioreq set):
  - bus_ready = 1 in IDLE; err_unmapped pulses on acceptance.
  - Unmapped read: go to FILL; FILL data is returned on the next cycle.
- Requests with neither qualifier set are never accepted (bus_ready = 0).
- State machine:
  - IDLE
    - accepted write → IDLE
    - accepted mapped read → WAIT; latch the channel index into ff_sel; clear the counter
    - accepted unmapped read → FILL
  - WAIT
    - ch_rdata_en[ff_sel] → IDLE, returning ch_rdata[ff_sel]
    - counter == TIMEOUT-1 with no strobe → IDLE, returning FILL and pulsing err_timeout
  - FILL → IDLE, returning FILL
- Only one read is outstanding at a time. bus_ready stays 0 outside IDLE.
- ch_rdata_en from unselected channels, and any strobe while in IDLE or FILL, is ignored. This includes late data arriving after a timeout.
- Write strobes produce no bus_rdata_en.

## Timing
- Reset values: bus_ready 0, bus_rdata 0, bus_rdata_en 0, ch_valid 0, err_* 0, state IDLE, counter 0, ff_sel 0.
- Request path is combinational: bus_valid → ch_valid, ch_ready → bus_ready, both in the same cycle.
- Read response is registered: ch_rdata_en[ff_sel] at cycle t gives bus_rdata_en = 1 and bus_rdata at t+1, for exactly one cycle.
- Unmapped read accepted at t: FILL strobe at t+2.
- Timeout: read accepted at t; with no strobe, bus_rdata_en = FILL at t+TIMEOUT+1, with err_timeout in the same cycle.
- If the strobe and timeout expiry coincide, the slave data wins and err_timeout is not asserted.
- Counter is ceil(log2(TIMEOUT+1)) bits, saturating; it counts only in WAIT.
- Earliest next acceptance is the cycle the FSM is back in IDLE, i.e. the cycle bus_rdata_en is high.
- Asynchronous reset mid-WAIT aborts the read: no strobe is generated, and all outputs take their reset values immediately.

## Structure
- Shared package (ip_bus_pkg):
  - state encoding (IDLE, WAIT, FILL);
  - the function clog2;
  - a decode-hit function (address, base, mask, io, memreq, ioreq) → hit.
- One sub-module, ip_bus_prio_enc: CH-bit hit vector → lowest set index plus any-hit flag. It is purely combinational and reused by future arbiters.
- The top level instantiates ip_bus_hub with CH = 4 to replace the OR-combined ready/rdata/rdata_en assigns.

## Test plan
- Test configuration: CH = 4, TIMEOUT = 8.
  - ch0: mem, base 0x0000, mask 0x8000.
  - ch1: mem, base 0x8000, mask 0x8000.
  - ch2: io, base 0x10, mask 0xF0.
- Mem read 0x1234 → ch_valid = 0001. ch0 strobes 0x5A three cycles later → bus_rdata_en with 0x5A one cycle after the strobe. No error.
- IO write 0x15 = 0xA5 → ch_valid = 0100 while ch2 holds ready low for 2 cycles → bus_ready high on the third cycle. No bus_rdata_en.
- IO read 0x80 (unmapped) → bus_ready = 1 immediately; err_unmapped pulse; bus_rdata = 0xFF strobe two cycles after acceptance.
- Mem read 0x9000 with ch1 never responding → err_timeout and 0xFF at acceptance+9. A late ch1 strobe at +12 is ignored.
- ch1 strobes exactly at the expiry cycle → slave data returned, no err_timeout.
- Assert reset during WAIT → all outputs 0 asynchronously. After release, a new read on ch0 completes normally.

Source files
------------

// File: rtl/ip_bus_pkg.sv
// Shared definitions for the bus hub slice.
//   state_e    : hub FSM state encoding (idle / waiting for slave / forced fill)
//   clog2      : ceiling log2, never less than 1 (usable for register widths)
//   decode_hit : one-channel address + qualifier compare
package ip_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StFill
  } state_e;

  // Ceiling log2 with a floor of 1 so the result is always a legal vector width.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Address compare on masked bits plus the request-qualifier check. Callers
  // zero-extend narrower addresses to 32 bits.
  function automatic logic decode_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask,
                                      input logic        io,
                                      input logic        memreq,
                                      input logic        ioreq);
    logic qual;
    qual = io ? ioreq : memreq;
    return qual && ((addr & mask) == (base & mask));
  endfunction

endpackage

// File: rtl/ip_bus_hub_if.sv
// Master-side bus bundle between the CPU and ip_bus_hub.
//   master : drives address, qualifiers, write, valid, wdata; receives ready/rdata
//   slave  : the hub's view (the reverse)
interface ip_bus_hub_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 8
);
  logic [AW-1:0] bus_address;
  logic          bus_memreq;
  logic          bus_ioreq;
  logic          bus_write;
  logic          bus_valid;
  logic          bus_ready;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_rdata_en;

  modport master (
    output bus_address, bus_memreq, bus_ioreq, bus_write, bus_valid, bus_wdata,
    input  bus_ready, bus_rdata, bus_rdata_en
  );

  modport slave (
    input  bus_address, bus_memreq, bus_ioreq, bus_write, bus_valid, bus_wdata,
    output bus_ready, bus_rdata, bus_rdata_en
  );
endinterface

// File: rtl/ip_bus_prio_enc.sv
// Priority encoder: lowest set bit of an N-bit hit vector.
//   hit : request/hit vector
//   idx : index of the lowest set bit (0 when none set)
//   any : at least one bit set
module ip_bus_prio_enc
  import ip_bus_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = clog2(N)
) (
  input  logic [N-1:0]    hit,
  output logic [IdxW-1:0] idx,
  output logic            any
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) begin
        idx = IdxW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ip_bus_hub.sv
// Slave-side interconnect between the CPU bus master and CH peripherals.
//   clk, reset   : clock, asynchronous active-high reset
//   bus          : master bundle (slave modport); request path is combinational,
//                  read response is registered
//   ch_valid     : per-channel request valid
//   ch_ready     : per-channel ready
//   ch_rdata     : per-channel read data, channel i in [i*DW +: DW]
//   ch_rdata_en  : per-channel read strobe
//   err_unmapped : pulse when a request hitting no channel is accepted
//   err_timeout  : pulse with the forced response of a timed-out read
// Address and write data reach the slaves directly, not through this block.
module ip_bus_hub
  import ip_bus_pkg::*;
#(
  parameter int unsigned      CH      = 4,
  parameter int unsigned      AW      = 16,
  parameter int unsigned      DW      = 8,
  parameter logic [CH*AW-1:0] CH_BASE = '0,
  parameter logic [CH*AW-1:0] CH_MASK = '0,
  parameter logic [CH-1:0]    CH_IO   = '0,
  parameter int unsigned      TIMEOUT = 255,
  parameter logic [DW-1:0]    FILL    = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  ip_bus_hub_if.slave        bus,
  output logic [CH-1:0]      ch_valid,
  input  logic [CH-1:0]      ch_ready,
  input  logic [CH*DW-1:0]   ch_rdata,
  input  logic [CH-1:0]      ch_rdata_en,
  output logic               err_unmapped,
  output logic               err_timeout
);

  localparam int unsigned IdxW = clog2(CH);
  localparam int unsigned CntW = clog2(TIMEOUT + 1);

  state_e          state_q;
  logic [IdxW-1:0] sel_q;
  logic [CntW-1:0] cnt_q;
  logic [DW-1:0]   rdata_q;
  logic            rdata_en_q;
  logic            err_to_q;

  logic [CH-1:0]   hit;
  logic [IdxW-1:0] sel;
  logic            any_hit;
  logic            qual;
  logic            idle;
  logic            accept;

  logic unused_wdata;
  assign unused_wdata = ^bus.bus_wdata;

  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(CH); i++) begin
      hit[i] = decode_hit(32'(bus.bus_address), 32'(CH_BASE[i*AW +: AW]),
                          32'(CH_MASK[i*AW +: AW]), CH_IO[i], bus.bus_memreq, bus.bus_ioreq);
    end
  end

  ip_bus_prio_enc #(
    .N    (CH),
    .IdxW (IdxW)
  ) u_prio_enc (
    .hit (hit),
    .idx (sel),
    .any (any_hit)
  );

  assign qual = bus.bus_memreq | bus.bus_ioreq;
  assign idle = (state_q == StIdle);

  always_comb begin
    ch_valid = '0;
    if (idle && any_hit) begin
      ch_valid[sel] = bus.bus_valid;
    end
  end

  // Unmapped qualified requests are absorbed by the hub itself; unqualified
  // requests are never accepted.
  assign bus.bus_ready = idle & (any_hit ? ch_ready[sel] : qual);
  assign accept        = bus.bus_valid & bus.bus_ready;
  assign err_unmapped  = accept & ~any_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      rdata_en_q <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      // Response outputs are single-cycle; data is zero whenever the strobe is low.
      rdata_q    <= '0;
      rdata_en_q <= 1'b0;
      err_to_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept && !bus.bus_write) begin
            if (any_hit) begin
              state_q <= StWait;
              sel_q   <= sel;
              cnt_q   <= '0;
            end else begin
              state_q <= StFill;
            end
          end
        end
        StWait: begin
          // Slave data takes priority over a coinciding timeout expiry.
          if (ch_rdata_en[sel_q]) begin
            state_q    <= StIdle;
            rdata_q    <= ch_rdata[sel_q*DW +: DW];
            rdata_en_q <= 1'b1;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            state_q    <= StIdle;
            rdata_q    <= FILL;
            rdata_en_q <= 1'b1;
            err_to_q   <= 1'b1;
          end else if (cnt_q != {CntW{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFill: begin
          state_q    <= StIdle;
          rdata_q    <= FILL;
          rdata_en_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.bus_rdata    = rdata_q;
  assign bus.bus_rdata_en = rdata_en_q;
  assign err_timeout      = err_to_q;

endmodule
